// File: rtl/fifo_feeder.sv
// rtl/fifo_feeder.sv - stages DEPTH words, then streams them oldest-first into the delay-line fifo
// Define FIFO_FEEDER_FLUSH_EN to append DEPTH zero-word shifts after the drain.
module fifo_feeder #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64,
  parameter int SKEW  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITS-1:0]            in_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       fifo_en,
  output logic [BITS-1:0]            fifo_d
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic [2:0] {S_LOAD, S_WAIT, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      skew_q, skew_d;
  logic [BITS-1:0] stage_q [DEPTH];
  logic [BITS-1:0] stage_d [DEPTH];
  logic            fifo_en_q, fifo_en_d;
  logic [BITS-1:0] fifo_d_q, fifo_d_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    skew_d  = skew_q;
    stage_d = stage_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid && count_q != FULL) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i)) stage_d[i] = in_data;
          end
          count_d = count_q + CW'(1);
        end else if (start && count_q == FULL) begin
          idx_d = '0;
          if (SKEW > 0) begin
            state_d = S_WAIT;
            skew_d  = 8'(SKEW - 1);
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_WAIT: begin
        if (skew_q == 8'd0) state_d = S_DRAIN;
        else                skew_d  = skew_q - 8'd1;
      end
      S_DRAIN: begin
        if (idx_q == LAST) begin
          idx_d = '0;
`ifdef FIFO_FEEDER_FLUSH_EN
          state_d = S_FLUSH;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_FLUSH: begin
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
    if (state_d == S_DONE) count_d = '0;

    // Outputs are registered from the next state so they line up with state_q.
    fifo_en_d = (state_d == S_DRAIN) || (state_d == S_FLUSH);
    fifo_d_d  = (state_d == S_DRAIN) ? stage_q[idx_d] : '0;
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      count_q   <= '0;
      idx_q     <= '0;
      skew_q    <= '0;
      fifo_en_q <= 1'b0;
      fifo_d_q  <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      skew_q    <= skew_d;
      fifo_en_q <= fifo_en_d;
      fifo_d_q  <= fifo_d_d;
      done_q    <= done_d;
      stage_q   <= stage_d;
    end
  end

  assign in_ready = (state_q == S_LOAD) && (count_q != FULL);
  assign busy     = (state_q != S_LOAD);
  assign done     = done_q;
  assign count    = count_q;
  assign fifo_en  = fifo_en_q;
  assign fifo_d   = fifo_d_q;

endmodule
